circuit_breaker_ctrl: RTL

Trading circuit-breaker FSM directly downstream of the cascade detector. It consumes the cascade CB override pulse and the raw rule-alert stream, and decides per cycle whether incoming orders are passed, throttled, or blocked. It exposes halt/throttle status, the remaining timer, and trip statistics to the host register interface.

---
 rtl/nanotrade_pkg.sv | 43 ++++
 rtl/cb_timer.sv | 48 ++++
 rtl/circuit_breaker_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nanotrade_pkg.sv
// Shared definitions for the nanotrade circuit-breaker slice: breaker state
// encodings, rule anomaly codes, HALT cause codes and the cascade duration helper.
package nanotrade_pkg;

  typedef enum logic [1:0] {
    CbNormal   = 2'd0,
    CbThrottle = 2'd1,
    CbHalt     = 2'd2,
    CbCooldown = 2'd3
  } cb_state_e;

  // Rule-engine anomaly codes
  localparam logic [2:0] AnomSpike  = 3'd1;
  localparam logic [2:0] AnomVolume = 3'd2;
  localparam logic [2:0] AnomFlash  = 3'd3;
  localparam logic [2:0] AnomStuff  = 3'd5;

  // Cause of the most recent HALT entry
  localparam logic [2:0] CauseNone      = 3'd0;
  localparam logic [2:0] CauseRuleFlash = 3'd3;
  localparam logic [2:0] CauseRetrip    = 3'd4;
  localparam logic [2:0] CauseCascade   = 3'd7;

  // Default timing
  localparam int unsigned DefThrottleCycles = 256;
  localparam int unsigned DefCooldownCycles = 128;
  localparam int unsigned DefDefaultHalt    = 1024;
  localparam int unsigned DefMinHalt        = 16;
  localparam int unsigned DefHaltShift      = 4;
  localparam int unsigned DefThrottleDiv    = 4;

  // Cascade HALT duration: param << shift, saturated to 16 bits, floored at min_halt
  function automatic logic [15:0] cascade_duration(input logic [7:0]  param,
                                                   input int unsigned shift,
                                                   input int unsigned min_halt);
    logic [31:0] wide;
    wide = 32'(param) << shift;
    if (wide > 32'h0000_FFFF) wide = 32'h0000_FFFF;
    if (wide < min_halt) wide = min_halt;
    return wide[15:0];
  endfunction

endpackage

// File: rtl/cb_timer.sv
// Loadable 16-bit down-counter for the circuit-breaker state timer.
// load: take load_val. ext: take load_val only if larger than the current count,
// otherwise keep counting down. dec: count down. The count never goes below zero.
module cb_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ext,
  input  logic             dec,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count,
  output logic             zero,
  output logic             one
);

  logic [Width-1:0] count_q, count_d;
  logic [Width-1:0] count_dec;

  assign zero      = (count_q == '0);
  assign one       = (count_q == Width'(1));
  assign count_dec = zero ? count_q : count_q - Width'(1);

  // Next count: load beats extend beats decrement
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (ext) begin
      count_d = (load_val > count_q) ? load_val : count_dec;
    end else if (dec) begin
      count_d = count_dec;
    end
  end

  // Counter register, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/circuit_breaker_ctrl.sv
// Trading circuit-breaker FSM: gates orders (pass / throttle / block) from the
// cascade override pulse and rule alerts, and reports status and trip statistics.
// Optional macro CB_STATS_EN enables the saturating rejected-order counter;
// without it reject_count is tied to zero.
module circuit_breaker_ctrl
  import nanotrade_pkg::*;
#(
  parameter int unsigned THROTTLE_CYCLES = DefThrottleCycles,
  parameter int unsigned COOLDOWN_CYCLES = DefCooldownCycles,
  parameter int unsigned DEFAULT_HALT    = DefDefaultHalt,
  parameter int unsigned MIN_HALT        = DefMinHalt,
  parameter int unsigned HALT_SHIFT      = DefHaltShift,
  parameter int unsigned THROTTLE_DIV    = DefThrottleDiv
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cascade_cb_load,
  input  logic [7:0]  cascade_cb_param,
  input  logic        rule_alert_any,
  input  logic [2:0]  rule_alert_type,
  input  logic        manual_resume,
  input  logic        order_valid,
  output logic        order_accept,
  output logic        order_reject,
  output logic [1:0]  cb_state,
  output logic        trading_halt,
  output logic [15:0] cb_remaining,
  output logic [7:0]  trip_count,
  output logic [2:0]  last_cause,
  output logic [15:0] reject_count
);

  localparam int unsigned PhaseW = $clog2(THROTTLE_DIV);

  cb_state_e         state_q, state_d;
  logic              halt_q;
  logic              accept_q, reject_q;
  logic [7:0]        trip_q;
  logic [2:0]        cause_q, cause_d;
  logic [PhaseW-1:0] phase_q, phase_d;

  logic        tmr_load, tmr_ext, tmr_dec;
  logic [15:0] tmr_val, tmr_count;
  logic        tmr_zero, tmr_one;

  logic        flash, other_alert, expire, trip_inc, throttled, grant;
  logic [15:0] cascade_dur;

  cb_timer #(
    .Width (16)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .ext      (tmr_ext),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  // Event decode and next-state / timer command selection, in event priority order
  always_comb begin
    cascade_dur = cascade_duration(cascade_cb_param, HALT_SHIFT, MIN_HALT);
    flash       = rule_alert_any && (rule_alert_type == AnomFlash);
    other_alert = rule_alert_any && !flash;
    // Zero is included so a stray zero count in a timed state still exits
    expire      = tmr_one || tmr_zero;

    state_d  = state_q;
    cause_d  = cause_q;
    trip_inc = 1'b0;
    tmr_load = 1'b0;
    tmr_ext  = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      CbNormal, CbThrottle: begin
        if (cascade_cb_load) begin
          state_d  = CbHalt;
          tmr_load = 1'b1;
          tmr_val  = cascade_dur;
          trip_inc = 1'b1;
          cause_d  = CauseCascade;
        end else if (flash) begin
          state_d  = CbHalt;
          tmr_load = 1'b1;
          tmr_val  = 16'(DEFAULT_HALT);
          trip_inc = 1'b1;
          cause_d  = CauseRuleFlash;
        end else if (other_alert) begin
          state_d  = CbThrottle;
          tmr_load = 1'b1;
          tmr_val  = 16'(THROTTLE_CYCLES);
        end else if (state_q == CbThrottle) begin
          tmr_dec = 1'b1;
          if (expire) state_d = CbNormal;
        end
      end
      CbHalt: begin
        if (cascade_cb_load) begin
          // Extension: keep the longer of the running and new durations
          tmr_ext = 1'b1;
          tmr_val = cascade_dur;
          cause_d = CauseCascade;
        end else if (flash) begin
          tmr_ext = 1'b1;
          tmr_val = 16'(DEFAULT_HALT);
        end else if (manual_resume || expire) begin
          state_d  = CbCooldown;
          tmr_load = 1'b1;
          tmr_val  = 16'(COOLDOWN_CYCLES);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CbCooldown: begin
        if (cascade_cb_load) begin
          state_d  = CbHalt;
          tmr_load = 1'b1;
          tmr_val  = cascade_dur;
          trip_inc = 1'b1;
          cause_d  = CauseCascade;
        end else if (rule_alert_any) begin
          state_d  = CbHalt;
          tmr_load = 1'b1;
          tmr_val  = 16'(DEFAULT_HALT);
          trip_inc = 1'b1;
          cause_d  = CauseRetrip;
        end else begin
          tmr_dec = 1'b1;
          if (expire) state_d = CbNormal;
        end
      end
    endcase
  end

  // Order gating uses the pre-transition state; phase restarts on every state change
  always_comb begin
    throttled = (state_q == CbThrottle) || (state_q == CbCooldown);
    grant     = (state_q == CbNormal) || (throttled && (phase_q == '0));
    phase_d   = phase_q;
    if (state_d != state_q) begin
      phase_d = '0;
    end else if (order_valid && throttled) begin
      phase_d = phase_q + PhaseW'(1);
    end
  end

  // FSM state and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CbNormal;
      halt_q   <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      trip_q   <= '0;
      cause_q  <= CauseNone;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      halt_q   <= (state_d == CbHalt);
      accept_q <= order_valid && grant;
      reject_q <= order_valid && !grant;
      if (trip_inc && (trip_q != 8'hFF)) trip_q <= trip_q + 8'd1;
      cause_q  <= cause_d;
      phase_q  <= phase_d;
    end
  end

`ifdef CB_STATS_EN
  logic [15:0] rej_cnt_q;

  // Saturating rejected-order count, updated alongside order_reject
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rej_cnt_q <= '0;
    end else if (order_valid && !grant && (rej_cnt_q != 16'hFFFF)) begin
      rej_cnt_q <= rej_cnt_q + 16'd1;
    end
  end

  assign reject_count = rej_cnt_q;
`else
  assign reject_count = '0;
`endif

  assign cb_state     = state_q;
  assign trading_halt = halt_q;
  assign cb_remaining = tmr_count;
  assign trip_count   = trip_q;
  assign last_cause   = cause_q;
  assign order_accept = accept_q;
  assign order_reject = reject_q;

endmodule
